fp_unit_sched: RTL and testbench
================================

Name: fp_unit_sched

Overview:
- Scheduler that shares one multi-cycle floating-point arithmetic unit between two requesters, using round-robin arbitration.
- Classifies both operands on the sign/exponent/mantissa fields (zero, inf, qNaN, sNaN). IEEE special cases are resolved locally and never occupy the unit.
- Sits between the integer/issue logic and the FP core in the FPU wrapper.

Parameters:
- WID, 32, operand width; 32 gives 8-bit exponent and 23-bit mantissa, 64 gives 11-bit exponent and 52-bit mantissa; other values unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0  in  1  requester 0 request; held with op0/a0/b0 stable until ack0
- op0  in  2  00 add, 01 sub, 10 mul, 11 div
- a0  in  WID  operand a
- b0  in  WID  operand b
- ack0  out  1  one-cycle grant pulse; operands captured
- req1, op1, a1, b1, ack1  as requester 0
- fu_ld  out  1  one-cycle start pulse to FP unit
- fu_op  out  2  op to FP unit
- fu_a  out  WID  operand a to FP unit
- fu_b  out  WID  operand b to FP unit
- fu_done  in  1  FP unit result valid (one-cycle pulse)
- fu_o  in  WID  FP unit result
- o  out  WID  result
- o_valid  out  1  one-cycle result pulse
- o_id  out  1  requester that owns o
- o_inv  out  1  invalid-operation flag, qualified by o_valid
- o_dz  out  1  divide-by-zero flag, qualified by o_valid

Behaviour:
- One clock (clk); rst is synchronous, active-high.
- Reset values:
  - all outputs 0; state IDLE
  - round-robin pointer favours requester 0
- Only one operation is in flight; all outputs are registered.
- States: IDLE, CLASS, ISSUE, WAIT, RES.
- IDLE: if any req is high at an edge, grant one requester.
  - Both requesting: grant the pointer's favourite.
  - Single requester: grant it.
  - On the grant edge: latch op, a, b and the granted id; pulse ackN next cycle; pointer := other requester; go to CLASS.
- CLASS (ack cycle): classify latched operands.
  - Exponent all ones and mantissa zero = inf.
  - Exponent all ones, mantissa nonzero = NaN: qNaN if mantissa MSB = 1, sNaN otherwise.
  - Exponent and mantissa zero = zero, either sign.
  - Special case: go to RES with the result computed at the edge. Otherwise: go to ISSUE.
- Special-case results, in priority order:
  - 1. a or b sNaN: o = the first NaN operand (a before b) with mantissa MSB forced 1; o_inv = 1.
  - 2. a or b qNaN: o = first NaN operand unchanged.
  - 3. Invalid: add inf + (-inf), sub inf - inf, mul 0 * inf, div 0/0, div inf/inf. o = canonical qNaN (sign 0, exp all ones, mantissa MSB 1, rest 0); o_inv = 1.
  - 4. div finite nonzero / 0: o = inf with sign a^b; o_dz = 1.
  - 5. Remaining inf operand cases (add/sub with one inf, mul inf * nonzero, div inf/finite): o = inf. Sign follows IEEE: add = inf's sign, sub with b inf = ~sign(b), mul/div = sign xor.
  - All other cases go to the FP unit, including zero operands that are not covered above.
- ISSUE: fu_ld = 1 for exactly one cycle; fu_op/fu_a/fu_b hold latched values from ISSUE until leaving WAIT; go to WAIT.
- WAIT: on the edge where fu_done = 1, o := fu_o and go to RES. No timeout. fu_done seen outside WAIT is ignored.
- RES: o_valid = 1 and o_id = granted id for one cycle; o_inv/o_dz are valid here and 0 otherwise. Go to IDLE.
  - A req sampled on the RES edge is granted directly (RES counts as IDLE for arbitration).
- Latency:
  - Special case: req edge T, ack at T+1, o_valid at T+2.
  - Unit path: ack T+1, fu_ld T+2, o_valid one cycle after the fu_done cycle.
- Requester contract: req may drop in the cycle after ack. A req held after ack is treated as a new request at the next IDLE.
- Requests never dropped: with both requesters continuously requesting, grants strictly alternate.
- rst mid-operation: abandon the in-flight op, no o_valid, state IDLE, pointer to 0. A late fu_done from the abandoned op is ignored because the state is not WAIT.

Optional Feature:
- FP_SCHED_BYPASS_EN defined: special-case resolution as above.
- Undefined:
  - CLASS always goes to ISSUE; all results come from the FP unit.
  - o_inv = 0 and o_dz = 0.
  - Classification logic removed.

Test Plan:
- WID=32, req0 only, add a=0x3F800000, b=0x40000000, unit returns 0x40400000 after 4 cycles -> ack0 at T+1, fu_ld at T+2, o=0x40400000, o_id=0, o_inv=0.
- req0 and req1 high together from reset, both held for 3 ops -> ack0, ack1, ack0 in order; o_id sequence 0,1,0.
- mul a=0x7F800000, b=0x00000000 -> fu_ld never pulses; o=0x7FC00000, o_inv=1, o_valid at T+2.
- div a=0xBF800000, b=0x80000000 -> o=0x7F800000, o_dz=1; a=0x7F800001 (sNaN), b=1.0 -> o=0x7FC00001, o_inv=1.
- rst asserted in WAIT, fu_done 2 cycles later -> no o_valid; next req0 granted normally with pointer at 0.
- Build without FP_SCHED_BYPASS_EN, mul 0*inf -> fu_ld pulses, o = fu_o, o_inv=0.

Source files
------------

// File: rtl/fp_unit_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_unit_sched: round-robin scheduler sharing one multi-cycle FP unit      |
// | between two requesters; FP_SCHED_BYPASS_EN resolves IEEE specials locally.|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fp_unit_sched #(
  parameter int WID = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [1:0]     op0,
  input  logic [WID-1:0] a0,
  input  logic [WID-1:0] b0,
  output logic           ack0,
  input  logic           req1,
  input  logic [1:0]     op1,
  input  logic [WID-1:0] a1,
  input  logic [WID-1:0] b1,
  output logic           ack1,
  output logic           fu_ld,
  output logic [1:0]     fu_op,
  output logic [WID-1:0] fu_a,
  output logic [WID-1:0] fu_b,
  input  logic           fu_done,
  input  logic [WID-1:0] fu_o,
  output logic [WID-1:0] o,
  output logic           o_valid,
  output logic           o_id,
  output logic           o_inv,
  output logic           o_dz
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLASS = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RES   = 3'd4
  } state_t;

  state_t         r_state;
  logic           r_ptr;
  logic           r_id;
  logic [1:0]     r_op;
  logic [WID-1:0] r_a;
  logic [WID-1:0] r_b;

  logic w_gnt_any;
  logic w_gnt_id;
  assign w_gnt_any = req0 | req1;
  assign w_gnt_id  = (req0 & req1) ? r_ptr : req1;

  logic           w_special;
  logic           w_inv;
  logic           w_dz;
  logic [WID-1:0] w_res;

`ifdef FP_SCHED_BYPASS_EN
  localparam int EW = (WID == 64) ? 11 : 8;
  localparam int MW = WID - 1 - EW;

  logic          w_sa, w_sb;
  logic [EW-1:0] w_ea, w_eb;
  logic [MW-1:0] w_ma, w_mb;
  logic          w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic          w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic          w_invalid, w_inf_case, w_inf_sign;

  assign {w_sa, w_ea, w_ma} = r_a;
  assign {w_sb, w_eb, w_mb} = r_b;
  assign w_a_nan  = (&w_ea) & (|w_ma);
  assign w_b_nan  = (&w_eb) & (|w_mb);
  assign w_a_snan = w_a_nan & ~w_ma[MW-1];
  assign w_b_snan = w_b_nan & ~w_mb[MW-1];
  assign w_a_inf  = (&w_ea) & ~(|w_ma);
  assign w_b_inf  = (&w_eb) & ~(|w_mb);
  assign w_a_zero = ~(|w_ea) & ~(|w_ma);
  assign w_b_zero = ~(|w_eb) & ~(|w_mb);

  always_comb begin
    w_invalid  = 1'b0;
    w_inf_case = w_a_inf | w_b_inf;
    w_inf_sign = w_sa ^ w_sb;
    case (r_op)
      2'b00: begin
        w_invalid  = w_a_inf & w_b_inf & (w_sa != w_sb);
        w_inf_sign = w_a_inf ? w_sa : w_sb;
      end
      2'b01: begin
        w_invalid  = w_a_inf & w_b_inf & (w_sa == w_sb);
        w_inf_sign = w_a_inf ? w_sa : ~w_sb;
      end
      2'b10: w_invalid = (w_a_zero & w_b_inf) | (w_a_inf & w_b_zero);
      default: begin
        w_invalid  = (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
        w_inf_case = w_a_inf;
      end
    endcase
  end

  // Priority chain: signalling NaN, quiet NaN, invalid, divide-by-zero, infinity.
  always_comb begin
    w_special = 1'b0;
    w_inv     = 1'b0;
    w_dz      = 1'b0;
    w_res     = '0;
    if (w_a_snan | w_b_snan) begin
      w_special     = 1'b1;
      w_inv         = 1'b1;
      w_res         = w_a_nan ? r_a : r_b;
      w_res[MW-1]   = 1'b1;
    end else if (w_a_nan | w_b_nan) begin
      w_special = 1'b1;
      w_res     = w_a_nan ? r_a : r_b;
    end else if (w_invalid) begin
      w_special = 1'b1;
      w_inv     = 1'b1;
      w_res     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    end else if ((r_op == 2'b11) & w_b_zero & ~w_a_zero & ~w_a_inf) begin
      w_special = 1'b1;
      w_dz      = 1'b1;
      w_res     = {w_sa ^ w_sb, {EW{1'b1}}, {MW{1'b0}}};
    end else if (w_inf_case) begin
      w_special = 1'b1;
      w_res     = {w_inf_sign, {EW{1'b1}}, {MW{1'b0}}};
    end
  end
`else
  assign w_special = 1'b0;
  assign w_inv     = 1'b0;
  assign w_dz      = 1'b0;
  assign w_res     = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      fu_ld   <= 1'b0;
      fu_op   <= '0;
      fu_a    <= '0;
      fu_b    <= '0;
      o       <= '0;
      o_valid <= 1'b0;
      o_id    <= 1'b0;
      o_inv   <= 1'b0;
      o_dz    <= 1'b0;
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      fu_ld   <= 1'b0;
      o_valid <= 1'b0;
      o_inv   <= 1'b0;
      o_dz    <= 1'b0;
      case (r_state)
        // RES arbitrates exactly like IDLE so back-to-back requests lose no cycle.
        S_IDLE, S_RES: begin
          if (w_gnt_any) begin
            r_op    <= w_gnt_id ? op1 : op0;
            r_a     <= w_gnt_id ? a1 : a0;
            r_b     <= w_gnt_id ? b1 : b0;
            r_id    <= w_gnt_id;
            ack0    <= ~w_gnt_id;
            ack1    <= w_gnt_id;
            r_ptr   <= ~w_gnt_id;
            r_state <= S_CLASS;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLASS: begin
          if (w_special) begin
            o       <= w_res;
            o_valid <= 1'b1;
            o_id    <= r_id;
            o_inv   <= w_inv;
            o_dz    <= w_dz;
            r_state <= S_RES;
          end else begin
            fu_ld   <= 1'b1;
            fu_op   <= r_op;
            fu_a    <= r_a;
            fu_b    <= r_b;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (fu_done) begin
            o       <= fu_o;
            o_valid <= 1'b1;
            o_id    <= r_id;
            fu_op   <= '0;
            fu_a    <= '0;
            fu_b    <= '0;
            r_state <= S_RES;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_unit_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp_unit_sched: scoreboard bench for fp_unit_sched with a stand-in     |
// | FP unit; expectations follow FP_SCHED_BYPASS_EN when it is defined.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fp_unit_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        ack0, ack1, fu_ld, fu_done = 1'b0;
  logic [1:0]  fu_op;
  logic [31:0] fu_a, fu_b, fu_o = '0, o;
  logic        o_valid, o_id, o_inv, o_dz;

  fp_unit_sched #(.WID(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
    .fu_ld(fu_ld), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
    .fu_done(fu_done), .fu_o(fu_o),
    .o(o), .o_valid(o_valid), .o_id(o_id), .o_inv(o_inv), .o_dz(o_dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] o;
    logic        inv;
    logic        dz;
    logic        unit;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eo;
    logic        sp;
    logic        inv;
    logic        dz;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_res = 0;
  int   n_ld = 0;
  int   last_done = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Stand-in FP unit: known operand sets give real IEEE results, others a scramble.
  function automatic logic [31:0] unit_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 2'b10 && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (op == 2'b10 && ((a == 32'h7F800000 && b == 32'h0) || (a == 32'h0 && b == 32'h7F800000)))
      return 32'h7FC00000;
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
  endfunction

  initial begin
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (fu_ld) begin
        r = unit_model(fu_op, fu_a, fu_b);
        repeat (3) @(posedge clk);
        #1 fu_done = 1'b1; fu_o = r;
        @(posedge clk);
        #1 fu_done = 1'b0; fu_o = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every result pulse.
  always @(negedge clk) begin
    exp_t e;
    if (fu_ld) n_ld++;
    if (fu_done) last_done = cyc;
    if (o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_o_valid", 32'(o_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result_o", o, e.o);
        chk("result_id", 32'(o_id), 32'(e.id));
        chk("result_inv", 32'(o_inv), 32'(e.inv));
        chk("result_dz", 32'(o_dz), 32'(e.dz));
        if (e.unit) chk("done_to_valid_latency", 32'(cyc - last_done), 32'd1);
      end
      n_res++;
    end
  end

  task automatic wait_results(input int target, input string name);
    int n = 0;
    while (n_res < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_result_count"}, 32'(n_res), 32'(target));
  endtask

  task automatic do_op(input logic id, input vec_t v);
    exp_t e;
    int   res0, ld0;
    logic sp;
`ifdef FP_SCHED_BYPASS_EN
    sp = v.sp;
    e  = '{id: id, o: v.eo, inv: v.inv, dz: v.dz, unit: !v.sp};
`else
    sp = 1'b0;
    e  = '{id: id, o: unit_model(v.op, v.a, v.b), inv: 1'b0, dz: 1'b0, unit: 1'b1};
`endif
    sb.push_back(e);
    res0 = n_res;
    ld0  = n_ld;
    @(posedge clk);
    #1;
    if (id) begin req1 = 1'b1; op1 = v.op; a1 = v.a; b1 = v.b; end
    else    begin req0 = 1'b1; op0 = v.op; a0 = v.a; b0 = v.b; end
    @(posedge clk);
    @(negedge clk);
    chk("ack_at_t1", {30'd0, ack1, ack0}, id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("fu_ld_at_t2", 32'(fu_ld), 32'(!sp));
    if (sp) chk("special_valid_at_t2", 32'(o_valid), 32'd1);
    wait_results(res0 + 1, "op");
    chk("fu_ld_pulses", 32'(n_ld - ld0), sp ? 32'd0 : 32'd1);
  endtask

  // Both requesters held; grants must alternate starting from requester 0.
  task automatic both_run(input int nops);
    int res0 = n_res;
    bit got;
    for (int k = 0; k < nops; k++) begin
      if (k % 2 == 0) sb.push_back('{id: 1'b0, o: 32'h40400000, inv: 1'b0, dz: 1'b0, unit: 1'b1});
      else            sb.push_back('{id: 1'b1, o: 32'h40800000, inv: 1'b0, dz: 1'b0, unit: 1'b1});
    end
    @(posedge clk);
    #1;
    req0 = 1'b1; op0 = 2'b00; a0 = 32'h3F800000; b0 = 32'h40000000;
    req1 = 1'b1; op1 = 2'b10; a1 = 32'h40000000; b1 = 32'h40000000;
    for (int k = 0; k < nops; k++) begin
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
        @(negedge clk);
        got = ack0 | ack1;
      end
      chk("ack_order", {30'd0, ack1, ack0}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k == nops - 1) begin
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
      end
    end
    wait_results(res0 + nops, "both");
    @(posedge clk);
  endtask

  vec_t vt[14];

  initial begin
    int res0;
    vt[0]  = '{2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{2'b10, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{2'b10, 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{2'b11, 32'hBF800000, 32'h80000000, 32'h7F800000, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00001, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{2'b00, 32'h3F800000, 32'hFFC00005, 32'hFFC00005, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{2'b10, 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{2'b11, 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b1, 1'b0};
    vt[10] = '{2'b10, 32'h00000000, 32'h40000000, 32'h00004002, 1'b0, 1'b0, 1'b0};
    vt[11] = '{2'b00, 32'h7FC00000, 32'h7F800001, 32'h7FC00000, 1'b1, 1'b1, 1'b0};
    vt[12] = '{2'b11, 32'h7F800000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 1'b0};
    vt[13] = '{2'b00, 32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'({ack0, ack1, fu_ld, o_valid, o_id, o_inv, o_dz, |o, |fu_a, |fu_b, fu_op}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    both_run(3);

    for (int i = 0; i < 14; i++) do_op(1'(i % 2), vt[i]);

    // Abandon an op in WAIT; its late fu_done must not produce a result.
    res0 = n_res;
    @(posedge clk);
    #1 req0 = 1'b1; op0 = 2'b00; a0 = 32'h3F800000; b0 = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    chk("rst_test_ack0", 32'(ack0), 32'd1);
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    chk("rst_test_fu_ld", 32'(fu_ld), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("rst_no_o_valid", 32'(n_res), 32'(res0));
    chk("rst_scoreboard_empty", 32'(sb.size()), 32'd0);

    both_run(2);

    chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
